// File: rtl/mem_bus_ctrl.sv
// MEM-stage load/store to single-beat bus bridge: lane steering, load extension, ack timeout, flush.
// Optional `MEM_ALIGN_CHECK_EN`: misaligned half/word accesses complete with err_o and never reach the bus.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             capture;
  logic             we_q, sext_q;
  logic [1:0]       size_q;
  logic [31:0]      addr_q, wdata_q;
  logic             misaligned;
  logic             in_req;
  logic             flushed;
  logic [3:0]       be;
  logic [31:0]      wd;
  logic [31:0]      load_ext;
  logic [7:0]       lb;
  logic [15:0]      lh;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((size_i == 2'b01) && addr_i[0]) ||
                      (size_i[1] && (addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Lane enables and replicated store data from the captured access
  always_comb begin
    be = 4'b1111;
    wd = wdata_q;
    case (size_q)
      2'b00: begin
        be = 4'(4'b0001 << addr_q[1:0]);
        wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed lane(s) down to bit 0 and extend
  always_comb begin
    case (addr_q[1:0])
      2'b00:   lb = bus_rdata_i[7:0];
      2'b01:   lb = bus_rdata_i[15:8];
      2'b10:   lb = bus_rdata_i[23:16];
      default: lb = bus_rdata_i[31:24];
    endcase
    lh = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{sext_q & lb[7]}}, lb};
      2'b01:   load_ext = {{16{sext_q & lh[15]}}, lh};
      default: load_ext = bus_rdata_i;
    endcase
  end

  assign flushed = flush_q | flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i && !flush_i) begin
          capture = 1'b1;
          if (misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        if (flush_i) flush_d = 1'b1;
        // Ack takes priority over a coincident timeout
        if (bus_ack_i) begin
          state_d = DONE;
          err_d   = 1'b0;
          if (!flushed) rdata_d = we_q ? '0 : load_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!flushed) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        flush_d = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (capture) begin
        we_q    <= we_i;
        size_q  <= size_i;
        sext_q  <= sext_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  assign in_req      = (state_q == REQ);
  assign bus_req_o   = in_req;
  assign bus_we_o    = in_req & we_q;
  assign bus_addr_o  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus_be_o    = in_req ? be : '0;
  assign bus_wdata_o = in_req ? wd : '0;

  // A flushed access still finishes on the bus but reports nothing
  assign done_o  = (state_q == DONE) & ~flush_q;
  assign err_o   = done_o & err_q;
  assign rdata_o = rdata_q;
  assign stall_o = req_i & (state_q != DONE) & ~flushed;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl built with TIMEOUT=4; follows MEM_ALIGN_CHECK_EN if defined.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0, sext_i = 1'b0, flush_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        stall_o, done_o, err_o, bus_req_o, bus_we_o, bus_ack_i = 1'b0;
  logic [31:0] rdata_o, bus_addr_o, bus_wdata_o, bus_rdata_i = '0;
  logic [3:0]  bus_be_o;

  int vectors = 0;
  int miscompares = 0;

  mem_bus_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sext_i(sext_i), .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [3:0]  be;
    logic [31:0] bwd;
  } st_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    req_i = 1'b1; we_i = we; size_i = sz; sext_i = sx; addr_i = a; wdata_i = wd;
    flush_i = 1'b0; bus_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    tick(); tick();
    rst = 1'b0; req_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    vectors++;
    if ({stall_o, done_o, err_o, rdata_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got stall=%b done=%b err=%b rdata=%h req=%b we=%b addr=%h be=%b wd=%h, want all zero",
               stall_o, done_o, err_o, rdata_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o);
    end
  endtask

  task automatic test_loads();
    ld_vec_t lv[6];
    lv[0] = '{2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
    lv[1] = '{2'b00, 1'b1, 32'h0000_0103, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80};
    lv[2] = '{2'b00, 1'b0, 32'h0000_0103, 32'h8012_3456, 4'b1000, 32'h0000_0080};
    lv[3] = '{2'b01, 1'b1, 32'h0000_0102, 32'h8001_5555, 4'b1100, 32'hFFFF_8001};
    lv[4] = '{2'b00, 1'b1, 32'h0000_0101, 32'h1234_7F56, 4'b0010, 32'h0000_007F};
    lv[5] = '{2'b01, 1'b0, 32'h0000_0100, 32'h1234_ABCD, 4'b0011, 32'h0000_ABCD};
    for (int i = 0; i < 6; i++) begin
      tick();
      start(1'b0, lv[i].size, lv[i].sext, lv[i].addr, 32'h0);
      #1;
      vectors++;
      if ({stall_o, bus_req_o} !== 2'b10) begin
        miscompares++;
        $display("FAIL load%0d_c0: stall/bus_req got %b want 10", i, {stall_o, bus_req_o});
      end
      tick();
      bus_ack_i = 1'b1; bus_rdata_i = lv[i].rdata;
      #1;
      vectors++;
      if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, stall_o, done_o} !==
          {1'b1, 1'b0, lv[i].addr & 32'hFFFF_FFFC, lv[i].be, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL load%0d_bus: got req=%b we=%b addr=%h be=%b stall=%b done=%b, want 1 0 %h %b 1 0",
                 i, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, stall_o, done_o,
                 lv[i].addr & 32'hFFFF_FFFC, lv[i].be);
      end
      tick();
      bus_ack_i = 1'b0;
      #1;
      vectors++;
      if ({done_o, err_o, stall_o, bus_req_o, rdata_o} !== {4'b1000, lv[i].exp}) begin
        miscompares++;
        $display("FAIL load%0d_done: got done=%b err=%b stall=%b req=%b rdata=%h, want 1 0 0 0 %h",
                 i, done_o, err_o, stall_o, bus_req_o, rdata_o, lv[i].exp);
      end
      req_i = 1'b0;
      tick();
      vectors++;
      if ({done_o, bus_req_o} !== 2'b00) begin
        miscompares++;
        $display("FAIL load%0d_idle: done/bus_req got %b want 00", i, {done_o, bus_req_o});
      end
    end
  endtask

  task automatic test_stores();
    st_vec_t sv[3];
    sv[0] = '{2'b01, 32'h0000_0202, 32'h0000_1234, 2, 4'b1100, 32'h1234_1234};
    sv[1] = '{2'b00, 32'h0000_0101, 32'h0000_00AB, 0, 4'b0010, 32'hABAB_ABAB};
    sv[2] = '{2'b10, 32'h0000_0300, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D};
    for (int i = 0; i < 3; i++) begin
      tick();
      start(1'b1, sv[i].size, 1'b0, sv[i].addr, sv[i].wdata);
      for (int c = 1; c <= sv[i].waits + 1; c++) begin
        tick();
        bus_ack_i = (c == sv[i].waits + 1);
        #1;
        vectors++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, stall_o, done_o} !==
            {2'b11, sv[i].addr & 32'hFFFF_FFFC, sv[i].be, sv[i].bwd, 2'b10}) begin
          miscompares++;
          $display("FAIL store%0d_c%0d: got req=%b we=%b addr=%h be=%b wd=%h stall=%b done=%b, want 1 1 %h %b %h 1 0",
                   i, c, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, stall_o, done_o,
                   sv[i].addr & 32'hFFFF_FFFC, sv[i].be, sv[i].bwd);
        end
      end
      tick();
      bus_ack_i = 1'b0;
      #1;
      vectors++;
      if ({done_o, err_o, stall_o, bus_req_o} !== 4'b1000) begin
        miscompares++;
        $display("FAIL store%0d_done: done/err/stall/req got %b want 1000", i, {done_o, err_o, stall_o, bus_req_o});
      end
      req_i = 1'b0;
    end
  endtask

  // k=0: ack arrives in the last allowed cycle (ack beats timeout); k=1: no ack at all
  task automatic test_timeout();
    for (int k = 0; k < 2; k++) begin
      tick();
      start(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
      for (int c = 1; c <= 4; c++) begin
        tick();
        bus_ack_i = (k == 0) && (c == 4);
        bus_rdata_i = 32'h55AA_55AA;
        #1;
        vectors++;
        if ({bus_req_o, stall_o, done_o} !== 3'b110) begin
          miscompares++;
          $display("FAIL timeout%0d_c%0d: req/stall/done got %b want 110", k, c, {bus_req_o, stall_o, done_o});
        end
      end
      tick();
      bus_ack_i = 1'b0;
      #1;
      vectors++;
      if ({done_o, err_o, bus_req_o, rdata_o} !== {1'b1, k == 1, 1'b0, (k == 1) ? 32'h0 : 32'h55AA_55AA}) begin
        miscompares++;
        $display("FAIL timeout%0d_done: got done=%b err=%b req=%b rdata=%h, want 1 %b 0 %h",
                 k, done_o, err_o, bus_req_o, rdata_o, k == 1, (k == 1) ? 32'h0 : 32'h55AA_55AA);
      end
      req_i = 1'b0;
    end
  endtask

  // rdata_o is 0 on entry (left by the timeout)
  task automatic test_flush_req();
    tick();
    start(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
    tick();
    flush_i = 1'b1;
    #1;
    vectors++;
    if ({bus_req_o, stall_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL flush_seen: bus_req/stall got %b want 10", {bus_req_o, stall_o});
    end
    tick();
    flush_i = 1'b0; req_i = 1'b0;
    #1;
    vectors++;
    if (bus_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_held: bus_req got %b want 1", bus_req_o);
    end
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_ack_i = 1'b0;
    #1;
    vectors++;
    if ({done_o, err_o, bus_req_o, rdata_o} !== {3'b000, 32'h0}) begin
      miscompares++;
      $display("FAIL flush_done: got done=%b err=%b req=%b rdata=%h, want 0 0 0 00000000",
               done_o, err_o, bus_req_o, rdata_o);
    end
    tick();
    vectors++;
    if ({done_o, bus_req_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_idle: done/bus_req got %b want 00", {done_o, bus_req_o});
    end
  endtask

  task automatic test_flush_idle();
    tick();
    start(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0);
    flush_i = 1'b1;
    #1;
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_stall: got %b want 0", stall_o);
    end
    tick();
    req_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    #1;
    vectors++;
    if (bus_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_noreq: bus_req got %b want 0", bus_req_o);
    end
    tick();
    bus_ack_i = 1'b0;
    #1;
    vectors++;
    if ({done_o, bus_req_o, rdata_o} !== {2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL stray_ack: got done=%b req=%b rdata=%h, want 0 0 00000000", done_o, bus_req_o, rdata_o);
    end
  endtask

  task automatic test_reset_in_req();
    tick();
    start(1'b0, 2'b10, 1'b0, 32'h0000_0700, 32'h0);
    tick();
    rst = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA_AAAA;
    tick();
    rst = 1'b0; req_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    vectors++;
    if ({bus_req_o, done_o, stall_o, rdata_o} !== {3'b000, 32'h0}) begin
      miscompares++;
      $display("FAIL rst_in_req: got req=%b done=%b stall=%b rdata=%h, want 0 0 0 00000000",
               bus_req_o, done_o, stall_o, rdata_o);
    end
    tick();
    vectors++;
    if ({bus_req_o, done_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_in_req_after: bus_req/done got %b want 00", {bus_req_o, done_o});
    end
  endtask

  task automatic test_misaligned();
    tick();
    start(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    vectors++;
    if ({bus_req_o, done_o, err_o, stall_o, rdata_o} !== {4'b0110, 32'h0}) begin
      miscompares++;
      $display("FAIL misaligned: got req=%b done=%b err=%b stall=%b rdata=%h, want 0 1 1 0 00000000",
               bus_req_o, done_o, err_o, stall_o, rdata_o);
    end
    req_i = 1'b0;
    tick();
    vectors++;
    if ({bus_req_o, done_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL misaligned_after: bus_req/done got %b want 00", {bus_req_o, done_o});
    end
`else
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
    #1;
    vectors++;
    if ({bus_req_o, bus_addr_o, bus_be_o} !== {1'b1, 32'h0000_0100, 4'b1111}) begin
      miscompares++;
      $display("FAIL misaligned_bus: got req=%b addr=%h be=%b, want 1 00000100 1111", bus_req_o, bus_addr_o, bus_be_o);
    end
    tick();
    bus_ack_i = 1'b0;
    #1;
    vectors++;
    if ({done_o, err_o, rdata_o} !== {2'b10, 32'h0BAD_F00D}) begin
      miscompares++;
      $display("FAIL misaligned_done: got done=%b err=%b rdata=%h, want 1 0 0badf00d", done_o, err_o, rdata_o);
    end
    req_i = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_timeout();
    test_flush_req();
    test_flush_idle();
    test_reset_in_req();
    test_misaligned();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles in REQ awaiting bus_ack_i before error; range 1..255.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_i  input  1  MEM stage has a load/store this cycle.
REQ-005 we_i  input  1  1 store, 0 load.
REQ-006 size_i  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-007 sext_i  input  1  load result sign-extended when 1, zero-extended when 0.
REQ-008 addr_i  input  32  byte address.
REQ-009 wdata_i  input  32  store data, right-aligned.
REQ-010 flush_i  input  1  pipeline flush; cancel/discard current access.
REQ-011 stall_o  output  1  freeze pipeline at MEM.
REQ-012 done_o  output  1  one-cycle pulse: access complete, rdata_o/err_o valid.
REQ-013 rdata_o  output  32  extended load data.
REQ-014 err_o  output  1  access failed (timeout or misalignment); valid with done_o.
REQ-015 bus_req_o  output  1  bus request.
REQ-016 bus_we_o  output  1  bus write.
REQ-017 bus_addr_o  output  32  word address; bits [1:0] always 00.
REQ-018 bus_be_o  output  4  byte-lane enables.
REQ-019 bus_wdata_o  output  32  lane-positioned store data.
REQ-020 bus_ack_i  input  1  bus completes the request in this cycle.
REQ-021 bus_rdata_i  input  32  read data, valid with bus_ack_i.

Function
REQ-022 FSM states IDLE, REQ, DONE; IDLE->REQ when req_i=1 and flush_i=0; REQ->DONE on bus_ack_i or timeout; DONE->IDLE unconditionally.
REQ-023 Leaving IDLE registers we_i, size_i, sext_i, addr_i, wdata_i; bus_* outputs driven from the registered copy only and held stable throughout REQ.
REQ-024 bus_req_o=1 exactly in REQ; earliest bus_req_o is the cycle after req_i rises; minimum latency req_i -> done_o with zero-wait ack is 2 cycles.
REQ-025 Byte enables: byte -> 0001 shifted left by addr[1:0]; half -> addr[1] ? 1100 : 0011; word -> 1111.
REQ-026 Store data: byte replicated to all four lanes; half replicated to both halves; word unchanged.
REQ-027 Load data: selected lane(s) shifted to bit 0, then extended to 32 bits per sext_i; word loads pass through unchanged.
REQ-028 stall_o = req_i AND state != DONE; stall_o=0 in DONE, so the pipeline advances exactly one cycle with done_o=1.
REQ-029 8-bit wait counter clears on entry to REQ and increments each REQ cycle without ack; when it reaches TIMEOUT, DONE is entered with err_o=1 and rdata_o=0.
REQ-030 bus_ack_i and timeout in the same cycle: ack wins, err_o=0.
REQ-031 flush_i in IDLE: no access starts. flush_i in REQ: the request is not withdrawn; it completes or times out, then done_o and err_o are suppressed, rdata_o is not updated, and stall_o drops once flush is seen.
REQ-032 bus_ack_i outside REQ is ignored.

Reset
REQ-033 When rst=1 at a clock edge, the FSM enters IDLE, the counter and flush flag clear, and all outputs are 0 in the following cycle, including rdata_o; rst overrides all other inputs.
REQ-034 Reset during REQ abandons the bus request: bus_req_o=0 from the next cycle and no done_o is produced.

Configuration
REQ-035 With macro MEM_ALIGN_CHECK_EN defined: a misaligned access (half with addr[0]=1; word with addr[1:0]!=00) skips REQ, goes IDLE->DONE, keeps bus_req_o=0, and produces done_o=1, err_o=1.
REQ-036 Without MEM_ALIGN_CHECK_EN: there is no check; the low address bits select lanes per REQ-025, and misaligned half/word accesses use addr[1] or the full word.

Verification
REQ-037 Word load addr 0x100, ack on first REQ cycle with bus_rdata_i=0xDEADBEEF: bus_addr_o=0x100, be=1111, and done_o pulses at cycle 2 with rdata_o=0xDEADBEEF.
REQ-038 Byte load addr 0x103, sext_i=1, rdata=0x80xxxxxx: be=1000 and rdata_o=0xFFFFFF80; repeat with sext_i=0: rdata_o=0x00000080.
REQ-039 Half store addr 0x202, wdata_i=0x1234: be=1100, bus_wdata_o=0x12341234, and stall_o stays high through a 3-cycle ack wait.
REQ-040 TIMEOUT=4 with ack never asserted: bus_req_o is high 4 cycles, then done_o=1, err_o=1, rdata_o=0.
REQ-041 flush_i pulsed during REQ, ack 2 cycles later: no done_o, rdata_o is unchanged, and the FSM returns to IDLE.
REQ-042 With MEM_ALIGN_CHECK_EN, word load at 0x101: bus_req_o never rises, and done_o=1, err_o=1 one cycle after req_i.
